// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Contents: opcode map, out_flags bit positions, FSM state encoding.
package alu_pkg;

   // Opcode map (4-bit); 0110 and 1011-1111 are illegal
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b0101;
   localparam logic [3:0] OP_DIV = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1000;
   localparam logic [3:0] OP_MOD = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;

   // Bit positions within out_flags = {ILL, DZ, V, C, Z}
   localparam int unsigned FLG_Z   = 0;
   localparam int unsigned FLG_C   = 1;
   localparam int unsigned FLG_V   = 2;
   localparam int unsigned FLG_DZ  = 3;
   localparam int unsigned FLG_ILL = 4;
   localparam int unsigned FLG_W   = 5;

   // Handshake FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU.
// Request side : in_valid, in_ready, in_a, in_b, in_op
// Response side: out_valid, out_ready, out_result, out_flags
//                (+ out_result_hi when ALU_SEQ_MULH_EN is defined)
// Modports: master = producer of requests / consumer of results, slave = ALU.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [3:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [4:0]       out_flags;
`ifdef ALU_SEQ_MULH_EN
   logic [WIDTH-1:0] out_result_hi;

   modport master (output in_valid, in_a, in_b, in_op, out_ready,
                   input  in_ready, out_valid, out_result, out_flags, out_result_hi);
   modport slave  (input  in_valid, in_a, in_b, in_op, out_ready,
                   output in_ready, out_valid, out_result, out_flags, out_result_hi);
`else
   modport master (output in_valid, in_a, in_b, in_op, out_ready,
                   input  in_ready, out_valid, out_result, out_flags);
   modport slave  (input  in_valid, in_a, in_b, in_op, out_ready,
                   output in_ready, out_valid, out_result, out_flags);
`endif
endinterface

// File: rtl/alu_seq_iter.sv
// Iterative multiply (shift-add) / restoring-divide engine.
// Ports: clk, rst_n; start loads a/b/mode_mul and performs the first step;
//        every later cycle with cnt != 0 performs one more step.
//        hi/lo: 2*WIDTH accumulator (MUL: product; DIV: hi=remainder, lo=quotient)
//        done_c: no steps remain (cnt == 0).
module alu_seq_iter #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode_mul,
   input  logic [CNT_W-1:0] cnt,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             done_c
);

   logic [WIDTH-1:0] hi_q, lo_q, b_q;
   logic             mul_q;

   logic [WIDTH-1:0] src_hi, src_lo, src_b;
   logic             src_mul;
   logic [WIDTH:0]   add_w, rem_w, sub_w;
   logic             ge;
   logic [WIDTH-1:0] hi_d, lo_d;

   // One step; on start it operates on the freshly presented operands
   always_comb begin
      src_hi  = start ? '0       : hi_q;
      src_lo  = start ? a        : lo_q;
      src_b   = start ? b        : b_q;
      src_mul = start ? mode_mul : mul_q;

      add_w = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);
      rem_w = {src_hi, src_lo[WIDTH-1]};
      sub_w = rem_w - {1'b0, src_b};
      ge    = (rem_w >= {1'b0, src_b});

      if (src_mul) begin
         hi_d = add_w[WIDTH:1];
         lo_d = {add_w[0], src_lo[WIDTH-1:1]};
      end else begin
         hi_d = ge ? sub_w[WIDTH-1:0] : rem_w[WIDTH-1:0];
         lo_d = {src_lo[WIDTH-2:0], ge};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         mul_q <= 1'b0;
      end else begin
         if (start) begin
            b_q   <= b;
            mul_q <= mode_mul;
         end
         if (start || (cnt != '0)) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
         end
      end
   end

   assign hi     = hi_q;
   assign lo     = lo_q;
   assign done_c = (cnt == '0);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes and status flags.
// Ports: clk, rst_n (async, active-low), bus (alu_seq_if.slave).
// Single-cycle ops complete with latency 1; MUL and DIV/MOD with b != 0
// run WIDTH iterations on alu_seq_iter.
// Optional: define ALU_SEQ_MULH_EN to add out_result_hi
// (MUL upper half, DIV remainder, MOD quotient; 0 otherwise).
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_seq_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [FLG_W-1:0] flags_q, flags_d;
`ifdef ALU_SEQ_MULH_EN
   logic [WIDTH-1:0] result_hi_q, result_hi_d, sc_hi;
`endif

   logic             accept_c, iter_op_c, iter_start_c, iter_done_c;
   logic [WIDTH-1:0] iter_hi, iter_lo;
   logic [WIDTH:0]   sum_c, diff_c;
   logic [WIDTH-1:0] sc_result;
   logic [FLG_W-1:0] sc_flags;

   assign accept_c     = bus.in_valid && in_ready_q;
   assign iter_op_c    = (bus.in_op == OP_MUL) ||
                         (((bus.in_op == OP_DIV) || (bus.in_op == OP_MOD)) && (bus.in_b != '0));
   assign iter_start_c = accept_c && iter_op_c;

   alu_seq_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (iter_start_c),
      .a        (bus.in_a),
      .b        (bus.in_b),
      .mode_mul (bus.in_op == OP_MUL),
      .cnt      (cnt_q),
      .hi       (iter_hi),
      .lo       (iter_lo),
      .done_c   (iter_done_c)
   );

   // Single-cycle result and flags from the live request
   always_comb begin
      sum_c     = {1'b0, bus.in_a} + {1'b0, bus.in_b};
      diff_c    = {1'b0, bus.in_a} - {1'b0, bus.in_b};
      sc_result = '0;
      sc_flags  = '0;
`ifdef ALU_SEQ_MULH_EN
      sc_hi     = '0;
`endif
      case (bus.in_op)
         OP_ADD: begin
            sc_result       = sum_c[WIDTH-1:0];
            sc_flags[FLG_C] = sum_c[WIDTH];
            sc_flags[FLG_V] = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                              (sum_c[WIDTH-1] != bus.in_a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_result       = diff_c[WIDTH-1:0];
            sc_flags[FLG_C] = diff_c[WIDTH];
            sc_flags[FLG_V] = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                              (diff_c[WIDTH-1] != bus.in_a[WIDTH-1]);
         end
         OP_AND: sc_result = bus.in_a & bus.in_b;
         OP_OR:  sc_result = bus.in_a | bus.in_b;
         OP_XOR: sc_result = bus.in_a ^ bus.in_b;
         OP_NOT: sc_result = ~bus.in_a;
         OP_LDI: sc_result = bus.in_b;
         OP_MUL: sc_result = '0;
         // Reached only with b == 0; nonzero divisors go to the engine
         OP_DIV: begin
            sc_result        = '1;
            sc_flags[FLG_DZ] = 1'b1;
`ifdef ALU_SEQ_MULH_EN
            sc_hi            = bus.in_a;
`endif
         end
         OP_MOD: begin
            sc_result        = bus.in_a;
            sc_flags[FLG_DZ] = 1'b1;
`ifdef ALU_SEQ_MULH_EN
            sc_hi            = '1;
`endif
         end
         default: sc_flags[FLG_ILL] = 1'b1;
      endcase
      sc_flags[FLG_Z] = !sc_flags[FLG_ILL] && (sc_result == '0);
   end

   // Handshake FSM and output register next-state
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
`ifdef ALU_SEQ_MULH_EN
      result_hi_d = result_hi_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               op_d = bus.in_op;
               if (iter_op_c) begin
                  state_d = ST_CALC;
                  // First step happens at accept; WIDTH-1 remain
                  cnt_d   = CNT_W'(WIDTH - 1);
               end else begin
                  state_d     = ST_DONE;
                  out_valid_d = 1'b1;
                  result_d    = sc_result;
                  flags_d     = sc_flags;
`ifdef ALU_SEQ_MULH_EN
                  result_hi_d = sc_hi;
`endif
               end
            end
         end
         ST_CALC: begin
            if (!iter_done_c) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               flags_d     = '0;
               if (op_q == OP_MOD) begin
                  result_d = iter_hi;
`ifdef ALU_SEQ_MULH_EN
                  result_hi_d = iter_lo;
`endif
               end else begin
                  result_d = iter_lo;
`ifdef ALU_SEQ_MULH_EN
                  result_hi_d = iter_hi;
`endif
               end
               flags_d[FLG_C] = (op_q == OP_MUL) && (iter_hi != '0);
               flags_d[FLG_Z] = (op_q == OP_MOD) ? (iter_hi == '0) : (iter_lo == '0);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
      in_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
`ifdef ALU_SEQ_MULH_EN
         result_hi_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
`ifdef ALU_SEQ_MULH_EN
         result_hi_q <= result_hi_d;
`endif
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = result_q;
   assign bus.out_flags  = flags_q;
`ifdef ALU_SEQ_MULH_EN
   assign bus.out_result_hi = result_hi_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16).
module tb_alu_seq;
   import alu_pkg::*;

   localparam int unsigned W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present one request, wait for acceptance, then wait for out_valid
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        output int lat);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         cyc();
         n++;
      end
      chk("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_op    = op;
      bus.in_valid = 1'b1;
      cyc();
      // Scramble inputs after accept; they must be don't-care now
      bus.in_valid = 1'b0;
      bus.in_a     = ~a;
      bus.in_b     = ~b;
      bus.in_op    = ~op;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         cyc();
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input int exp_lat,
                         input logic [15:0] exp_res, input logic [4:0] exp_flags,
                         input logic [15:0] exp_hi);
      int lat;
      issue(a, b, op, lat);
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_result"}, 32'(bus.out_result), 32'(exp_res));
      chk({tag, "_flags"}, 32'(bus.out_flags), 32'(exp_flags));
`ifdef ALU_SEQ_MULH_EN
      chk({tag, "_result_hi"}, 32'(bus.out_result_hi), 32'(exp_hi));
`else
      if (exp_hi != exp_hi) $display("unreachable");
`endif
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  seen;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_op     = '0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) cyc();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_result", 32'(bus.out_result), 32'd0);
      chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Flags {ILL,DZ,V,C,Z}
      run_op("add_wrap",  16'hFFFF, 16'h0001, OP_ADD, 1,  16'h0000, 5'b00011, 16'h0000);
      run_op("mul_300",   16'd300,  16'd300,  OP_MUL, 17, 16'h5F90, 5'b00010, 16'h0001);
      run_op("div_1000_7",16'd1000, 16'd7,    OP_DIV, 17, 16'h008E, 5'b00000, 16'h0006);
      run_op("mod_1000_7",16'd1000, 16'd7,    OP_MOD, 17, 16'h0006, 5'b00000, 16'h008E);
      run_op("div_by0",   16'd5,    16'd0,    OP_DIV, 1,  16'hFFFF, 5'b01000, 16'h0005);
      run_op("mod_by0",   16'd5,    16'd0,    OP_MOD, 1,  16'h0005, 5'b01000, 16'hFFFF);
      run_op("ill_0110",  16'h1234, 16'h5678, 4'b0110, 1, 16'h0000, 5'b10000, 16'h0000);
      run_op("ill_1111",  16'hFFFF, 16'hFFFF, 4'b1111, 1, 16'h0000, 5'b10000, 16'h0000);
      run_op("sub_borrow",16'd3,    16'd5,    OP_SUB, 1,  16'hFFFE, 5'b00010, 16'h0000);
      run_op("sub_ovf",   16'h8000, 16'h0001, OP_SUB, 1,  16'h7FFF, 5'b00100, 16'h0000);
      run_op("add_ovf",   16'h7FFF, 16'h0001, OP_ADD, 1,  16'h8000, 5'b00100, 16'h0000);
      run_op("and",       16'hF0F0, 16'h0FF0, OP_AND, 1,  16'h00F0, 5'b00000, 16'h0000);
      run_op("or",        16'hF000, 16'h000F, OP_OR,  1,  16'hF00F, 5'b00000, 16'h0000);
      run_op("xor_zero",  16'hA5A5, 16'hA5A5, OP_XOR, 1,  16'h0000, 5'b00001, 16'h0000);
      run_op("not",       16'hFFFF, 16'h1234, OP_NOT, 1,  16'h0000, 5'b00001, 16'h0000);
      run_op("ldi",       16'h1111, 16'hABCD, OP_LDI, 1,  16'hABCD, 5'b00000, 16'h0000);
      run_op("mul_zero",  16'd0,    16'd5,    OP_MUL, 17, 16'h0000, 5'b00001, 16'h0000);
      run_op("mul_max",   16'hFFFF, 16'hFFFF, OP_MUL, 17, 16'h0001, 5'b00010, 16'hFFFE);
      run_op("div_small", 16'd7,    16'd1000, OP_DIV, 17, 16'h0000, 5'b00001, 16'h0007);

      // Backpressure: result held, new request refused
      run_op("bp_pre",    16'd1, 16'd1, OP_ADD, 1, 16'd2, 5'b00000, 16'h0000);
      begin
         int lat;
         issue(16'd2, 16'd3, OP_ADD, lat);
         chk("bp_latency", 32'(lat), 32'd1);
         bus.in_valid = 1'b1;
         bus.in_a     = 16'd9;
         bus.in_b     = 16'd9;
         bus.in_op    = OP_SUB;
         for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp_hold_result", 32'(bus.out_result), 32'd5);
            chk("bp_hold_flags", 32'(bus.out_flags), 32'd0);
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            chk("bp_valid_high", 32'(bus.out_valid), 32'd1);
         end
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         cyc();
         bus.out_ready = 1'b0;
         chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
         chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
         repeat (3) cyc();
         chk("bp_no_stray_accept", 32'(bus.out_valid), 32'd0);
      end

      // Reset in the middle of a MUL
      n = 0;
      while (!bus.in_ready && n < 50) begin
         cyc();
         n++;
      end
      bus.in_a     = 16'd300;
      bus.in_b     = 16'd300;
      bus.in_op    = OP_MUL;
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      repeat (4) cyc();
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("midrst_out_result", 32'(bus.out_result), 32'd0);
      repeat (2) cyc();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         cyc();
         if (bus.out_valid) seen = 1'b1;
      end
      chk("midrst_no_emit", 32'(seen), 32'd0);
      run_op("post_rst_add", 16'h1234, 16'h0001, OP_ADD, 1, 16'h1235, 5'b00000, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor of the 16-bit combinational ALU. It keeps the same 4-bit opcode map. Operand width is generic, and input and output use valid/ready handshakes. MUL, DIV and MOD run on an iterative shift-add / restoring-divide datapath instead of single-cycle operators. It also adds status flags. The block sits between the decode/register-read stage and writeback.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock; asynchronous assert, active-low
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  4  opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 MUL, 0111 DIV, 1000 NOT, 1001 MOD, 1010 LDI
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result
out_flags  output  5  {ILL, DZ, V, C, Z}

Behaviour:
- FSM states: IDLE, CALC, DONE. Reset forces IDLE and clears the datapath: out_valid=0, out_result=0, out_flags=0, counter=0. in_ready=0 while rst_n is low.
- in_ready = (state==IDLE). Accept occurs when in_valid && in_ready. a, b and op are latched at accept and are don't-care afterwards.
- Single-cycle ops are ADD, SUB, AND, OR, XOR, NOT, LDI, illegal opcodes, and DIV/MOD with b==0. On accept: result/flags registered, IDLE->DONE, out_valid=1 on the next cycle (latency 1).
- MUL, DIV and MOD with b!=0: IDLE->CALC. One iteration per cycle for WIDTH cycles, then ->DONE. out_valid rises WIDTH+1 cycles after accept.
- DONE: out_valid=1. out_result and out_flags are held stable until out_valid && out_ready, then ->IDLE. There is no overlap: a new accept is possible earliest the cycle after the output handshake.
- Arithmetic:
  - Unsigned operands.
  - ADD/SUB result truncated to WIDTH.
  - MUL returns the low WIDTH bits of the 2*WIDTH product.
  - DIV returns the quotient; MOD returns the remainder.
  - NOT = ~a; LDI = b.
- Flags:
  - Z = (result==0) for all legal ops.
  - C: ADD carry-out; SUB borrow (a<b); MUL upper half of product !=0; 0 otherwise.
  - V: signed overflow for ADD/SUB only; 0 otherwise.
  - DZ: DIV/MOD with b==0. Result is all-ones for DIV and a for MOD; Z is computed from that result.
  - ILL: opcode 0110 or 1011-1111; result 0, all other flags 0.
- Reset mid-CALC or mid-DONE: the operation is aborted, nothing is emitted, and the block returns to IDLE.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

Optional Feature:
Macro ALU_SEQ_MULH_EN.
- Defined: adds output out_result_hi (WIDTH), valid with out_valid. It carries the MUL upper product half and the DIV remainder / MOD quotient; it is 0 for other ops. Reset value 0.
- Undefined: the port and its holding register are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_ADD..OP_LDI)
  - flag bit indices (FLG_Z=0, FLG_C=1, FLG_V=2, FLG_DZ=3, FLG_ILL=4)
  - FSM state encoding
- Sub-module alu_seq_iter: iterative multiply/divide engine. It has start, a, b, mode (mul/div) and counter inputs, and produces a 2*WIDTH accumulator (hi, lo) and done.
- alu_seq owns the handshake FSM, the single-cycle ops and flag generation.

Test Plan (WIDTH=16):
1. ADD a=0xFFFF b=0x0001 -> out_result=0x0000, Z=1, C=1, V=0; out_valid exactly 1 cycle after accept.
2. MUL a=300 b=300 -> out_result=0x5F90, C=1; out_valid 17 cycles after accept. With ALU_SEQ_MULH_EN, out_result_hi=0x0001.
3. DIV a=1000 b=7 -> 0x008E at latency 17; MOD with the same operands -> 0x0006, Z=0.
4. DIV a=5 b=0 -> out_result=0xFFFF, DZ=1, latency 1. Opcode 0110 -> result 0x0000, ILL=1.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid, driving in_valid=1 with a new op -> result/flags unchanged, in_ready=0, new op not accepted. out_ready=1 -> in_ready=1 the next cycle.
6. Assert rst_n=0 at cycle 5 of a MUL -> out_valid=0, no result emitted. After release, ADD 0x1234+0x0001 -> 0x1235 at latency 1.
